// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store sequencer: access-width codes, FSM states, lane geometry.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LDFMT,
    RMW,
    WR,
    RESP
  } state_t;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle of the load/store sequencer.
interface mem_access_unit_if #(
  parameter int n = 32
) ();
  logic         req;
  logic         we;
  logic [2:0]   funct3;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic         busy;
  logic         done;
  logic         fault;
  logic [n-1:0] rdata;

  modport master (
    output req, we, funct3, addr, wdata,
    input  busy, done, fault, rdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output busy, done, fault, rdata
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lane_align
  import mem_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   off,
  input  logic [n-1:0] word,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] ld_data,
  output logic [n-1:0] st_data
);
  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  always_comb begin
    byte_v  = word[{off, 3'b000} +: BYTE_W];
    half_v  = word[{off[1], 4'b0000} +: HALF_W];
    ld_data = word;
    st_data = word;
    case (funct3)
      OP_B: begin
        ld_data = {{(n-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
        st_data[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      OP_BU: ld_data = {{(n-BYTE_W){1'b0}}, byte_v};
      OP_H: begin
        ld_data = {{(n-HALF_W){half_v[HALF_W-1]}}, half_v};
        st_data[{off[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      end
      OP_HU: ld_data = {{(n-HALF_W){1'b0}}, half_v};
      default: st_data = wdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core memory stage and a one-cycle-latency synchronous RAM.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int n  = 32,
  parameter int AW = 6
) (
  input  logic            clock,
  input  logic            nReset,
  mem_access_unit_if.slave core,
  output logic            ramR,
  output logic            ramW,
  output logic [AW-1:0]   ramAddr,
  output logic [n-1:0]    ramDataW,
  input  logic [n-1:0]    ramDataR
);
  state_t        state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [n-1:0]  wdata_q;
  logic [n-1:0]  rdata_q;
  logic [n-1:0]  ld_data;
  logic          misal, oor, illegal;

  always_comb begin
    misal   = ((core.funct3 == OP_H || core.funct3 == OP_HU) && core.addr[0]) ||
              ((core.funct3 == OP_W) && (core.addr[1:0] != 2'b00));
    oor     = |core.addr[n-1:AW+2];
    illegal = (core.funct3 == 3'b011) || (core.funct3[2:1] == 2'b11) ||
              (core.we && core.funct3[2]);
  end

  // Merge data is combinational because ramDataR only arrives in the RMW cycle itself.
  lane_align #(.n(n)) u_lane (
    .funct3  (f3_q),
    .off     (addr_q[1:0]),
    .word    (ramDataR),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (ramDataW)
  );

  assign ramAddr    = addr_q[AW+1:2];
  assign core.rdata = rdata_q;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      core.busy  <= 1'b0;
      core.done  <= 1'b0;
      core.fault <= 1'b0;
      ramR       <= 1'b0;
      ramW       <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core.req) begin
            we_q      <= core.we;
            f3_q      <= core.funct3;
            addr_q    <= core.addr[AW+1:0];
            wdata_q   <= core.wdata;
            core.busy <= 1'b1;
            if (misal || oor || illegal) begin
              state      <= RESP;
              core.done  <= 1'b1;
              core.fault <= 1'b1;
            end else if (core.we && core.funct3 == OP_W) begin
              state <= WR;
              ramW  <= 1'b1;
            end else begin
              state <= RD;
              ramR  <= 1'b1;
            end
          end
        end
        RD: begin
          ramR <= 1'b0;
          if (we_q) begin
            state <= RMW;
            ramW  <= 1'b1;
          end else begin
            state <= LDFMT;
          end
        end
        LDFMT: begin
          rdata_q   <= ld_data;
          state     <= RESP;
          core.done <= 1'b1;
        end
        RMW, WR: begin
          ramW      <= 1'b0;
          state     <= RESP;
          core.done <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          core.busy  <= 1'b0;
          core.done  <= 1'b0;
          core.fault <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a behavioural one-cycle RAM.
module tb_mem_access_unit;
  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        ramR, ramW;
  logic [5:0]  ramAddr;
  logic [31:0] ramDataW;
  logic [31:0] ramDataR = 32'h0;
  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  typedef struct { logic fault; logic [31:0] rdata; } exp_t;
  exp_t sbq[$];
  logic [31:0] rd_m = 32'h0;

  mem_access_unit_if #(.n(32)) core_if ();

  mem_access_unit #(.n(32), .AW(6)) dut (
    .clock    (clock),
    .nReset   (nReset),
    .core     (core_if),
    .ramR     (ramR),
    .ramW     (ramW),
    .ramAddr  (ramAddr),
    .ramDataW (ramDataW),
    .ramDataR (ramDataR)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ramR) ramDataR <= mem[ramAddr];
    if (ramW) mem[ramAddr] <= ramDataW;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    if (nReset && (ramR || ramW)) chk("ramR_ramW_exclusive", {31'b0, ramR & ramW}, 32'h0);
    if (nReset && core_if.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_fault", {31'b0, core_if.fault}, {31'b0, e.fault});
        chk("resp_rdata", core_if.rdata, e.rdata);
      end
    end
  end

  task automatic do_op(input string nm, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic xfault,
                       input logic [31:0] xword, input int xlat,
                       input logic [7:0] xr, input logic [7:0] xw, input bit pulse);
    logic [7:0]  rmask = 8'h0;
    logic [7:0]  wmask = 8'h0;
    logic [31:0] wdat  = 32'h0;
    logic [5:0]  wadr  = 6'h0;
    int lat = 0;
    int extra = 0;
    exp_t e;
    if (!xfault && !w) rd_m = xword;
    e.fault = xfault;
    e.rdata = rd_m;
    sbq.push_back(e);
    @(negedge clock);
    core_if.req = 1'b1; core_if.we = w; core_if.funct3 = f3;
    core_if.addr = a; core_if.wdata = d;
    @(posedge clock);
    #1 core_if.req = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clock);
      if (pulse && c == 1) begin
        core_if.req = 1'b1; core_if.we = 1'b0; core_if.funct3 = 3'b010; core_if.addr = 32'h0;
      end else begin
        core_if.req = 1'b0;
      end
      rmask[c] = ramR;
      wmask[c] = ramW;
      if (ramW) begin wdat = ramDataW; wadr = ramAddr; end
      if (core_if.done) begin lat = c; break; end
    end
    core_if.req = 1'b0;
    if (lat == 0) chk({nm, "_timeout"}, 32'h0, 32'h1);
    chk({nm, "_latency"}, lat, xlat);
    chk({nm, "_ramR_cycles"}, {24'b0, rmask}, {24'b0, xr});
    chk({nm, "_ramW_cycles"}, {24'b0, wmask}, {24'b0, xw});
    if (xw != 8'h0) begin
      chk({nm, "_ramDataW"}, wdat, xword);
      chk({nm, "_ramAddr"}, {26'b0, wadr}, {26'b0, a[7:2]});
    end
    if (pulse) begin
      repeat (4) begin
        @(negedge clock);
        if (core_if.done) extra++;
      end
      chk({nm, "_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    core_if.req = 1'b0; core_if.we = 1'b0; core_if.funct3 = 3'b0;
    core_if.addr = 32'h0; core_if.wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy",  {31'b0, core_if.busy},  32'h0);
    chk("rst_done",  {31'b0, core_if.done},  32'h0);
    chk("rst_fault", {31'b0, core_if.fault}, 32'h0);
    chk("rst_rdata", core_if.rdata, 32'h0);
    chk("rst_ram_en", {30'b0, ramR, ramW}, 32'h0);
    @(negedge clock);
    nReset = 1'b1;

    do_op("sw",   1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2, 8'h00, 8'h02, 0);
    do_op("lb",   0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 3, 8'h02, 8'h00, 0);
    do_op("lbu",  0, 3'b100, 32'h13, 32'h0, 0, 32'h000000DE, 3, 8'h02, 8'h00, 0);
    do_op("lh",   0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFBEEF, 3, 8'h02, 8'h00, 0);
    do_op("lhu",  0, 3'b101, 32'h12, 32'h0, 0, 32'h0000DEAD, 3, 8'h02, 8'h00, 0);
    do_op("lb0",  0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 3, 8'h02, 8'h00, 0);
    do_op("sb",   1, 3'b000, 32'h11, 32'h00000055, 0, 32'hDEAD55EF, 3, 8'h02, 8'h04, 0);
    do_op("lw1",  0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD55EF, 3, 8'h02, 8'h00, 0);
    do_op("sh",   1, 3'b001, 32'h12, 32'h12347777, 0, 32'h777755EF, 3, 8'h02, 8'h04, 0);
    do_op("lw2",  0, 3'b010, 32'h10, 32'h0, 0, 32'h777755EF, 3, 8'h02, 8'h00, 0);
    do_op("swtop",1, 3'b010, 32'hFC, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2, 8'h00, 8'h02, 0);
    do_op("lwtop",0, 3'b010, 32'hFC, 32'h0, 0, 32'hCAFEF00D, 3, 8'h02, 8'h00, 0);
    do_op("f_lwmis", 0, 3'b010, 32'h12,  32'h0, 1, 32'h0, 1, 8'h00, 8'h00, 0);
    do_op("f_shmis", 1, 3'b001, 32'h01,  32'hFFFF, 1, 32'h0, 1, 8'h00, 8'h00, 0);
    do_op("f_011",   0, 3'b011, 32'h00,  32'h0, 1, 32'h0, 1, 8'h00, 8'h00, 0);
    do_op("f_range", 0, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1, 8'h00, 8'h00, 0);
    do_op("f_sbu",   1, 3'b100, 32'h10,  32'h1, 1, 32'h0, 1, 8'h00, 8'h00, 0);
    do_op("sb_busy", 1, 3'b000, 32'h10, 32'h000000AB, 0, 32'h777755AB, 3, 8'h02, 8'h04, 1);
    do_op("lw3",  0, 3'b010, 32'h10, 32'h0, 0, 32'h777755AB, 3, 8'h02, 8'h00, 0);

    do_op("sw5",  1, 3'b010, 32'h14, 32'h11223344, 0, 32'h11223344, 2, 8'h00, 8'h02, 0);
    @(negedge clock);
    core_if.req = 1'b1; core_if.we = 1'b1; core_if.funct3 = 3'b001;
    core_if.addr = 32'h14; core_if.wdata = 32'h0000AAAA;
    @(posedge clock);
    #1 core_if.req = 1'b0;
    @(negedge clock);
    chk("abort_ramR_before", {31'b0, ramR}, 32'h1);
    #1 nReset = 1'b0;
    #1;
    chk("abort_ramR_after", {31'b0, ramR}, 32'h0);
    chk("abort_ramW", {31'b0, ramW}, 32'h0);
    chk("abort_busy", {31'b0, core_if.busy}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    nReset = 1'b1;
    rd_m = 32'h0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_done", {30'b0, core_if.done, ramW}, 32'h0);
    end
    chk("abort_rdata_cleared", core_if.rdata, 32'h0);
    do_op("lw5",  0, 3'b010, 32'h14, 32'h0, 0, 32'h11223344, 3, 8'h02, 8'h00, 0);

    repeat (2) @(negedge clock);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
